// File: rtl/uart_cmd_decoder.sv
// Keyboard byte parser: maps UART bytes to start/up/down strobes and validated MM:SS loads.
// Optional idle-entry timeout is compiled in with `define UART_CMD_TIMEOUT_EN.
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_dout,
  output logic       start_pulse,
  output logic       up_pulse,
  output logic       dwn_pulse,
  output logic       load_valid,
  output logic [5:0] load_minutes,
  output logic [5:0] load_seconds,
  output logic       cmd_error,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_READY = 2'd2
  } state_e;

  if (TIMEOUT_CYCLES < 32'd2) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  function automatic logic [6:0] tens_ones(input logic [3:0] t, input logic [3:0] o);
    logic [6:0] t7;
    t7 = {3'b000, t};
    return (t7 << 3) + (t7 << 1) + {3'b000, o};
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  d_q [4];
  logic [3:0]  d_d [4];
  logic        start_q, start_d;
  logic        up_q, up_d;
  logic        dwn_q, dwn_d;
  logic        load_valid_q, load_valid_d;
  logic        cmd_error_q, cmd_error_d;
  logic        busy_q, busy_d;
  logic [5:0]  min_q, min_d;
  logic [5:0]  sec_q, sec_d;
  logic [6:0]  mins_s;
  logic [6:0]  secs_s;
  logic        is_digit_s;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 32'd1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_expire_s;
`endif

  assign mins_s     = tens_ones(d_q[0], d_q[1]);
  assign secs_s     = tens_ones(d_q[2], d_q[3]);
  assign is_digit_s = (rx_dout >= 8'h30) && (rx_dout <= 8'h39);

  // Next-state, digit capture and strobe decode for one received byte per cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    d_d          = d_q;
    start_d      = 1'b0;
    up_d         = 1'b0;
    dwn_d        = 1'b0;
    load_valid_d = 1'b0;
    cmd_error_d  = 1'b0;
    min_d        = min_q;
    sec_d        = sec_q;
`ifdef UART_CMD_TIMEOUT_EN
    tmo_expire_s = busy_q && (tmo_q == TMO_LAST);
    if (rx_done_tick || !busy_q || tmo_expire_s) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
    end
`endif
    if (rx_done_tick) begin
      case (rx_dout)
        8'h20, 8'h55, 8'h75, 8'h44, 8'h64: begin
          if (state_q == ST_IDLE) begin
            start_d = (rx_dout == 8'h20);
            up_d    = (rx_dout == 8'h55) || (rx_dout == 8'h75);
            dwn_d   = (rx_dout == 8'h44) || (rx_dout == 8'h64);
          end else begin
            // A command key in the middle of an entry kills the entry instead.
            cmd_error_d = 1'b1;
            state_d     = ST_IDLE;
            cnt_d       = 2'd0;
          end
        end
        8'h0D: begin
          case (state_q)
            ST_READY: begin
              if ((mins_s < 7'd60) && (secs_s < 7'd60)) begin
                load_valid_d = 1'b1;
                min_d        = mins_s[5:0];
                sec_d        = secs_s[5:0];
              end else begin
                cmd_error_d = 1'b1;
              end
              state_d = ST_IDLE;
              cnt_d   = 2'd0;
            end
            ST_ENTRY: begin
              cmd_error_d = 1'b1;
              state_d     = ST_IDLE;
              cnt_d       = 2'd0;
            end
            default: begin
              state_d = state_q;
            end
          endcase
        end
        8'h1B: begin
          state_d = ST_IDLE;
          cnt_d   = 2'd0;
        end
        default: begin
          if (is_digit_s) begin
            case (state_q)
              ST_IDLE: begin
                d_d[0]  = rx_dout[3:0];
                cnt_d   = 2'd1;
                state_d = ST_ENTRY;
              end
              ST_ENTRY: begin
                d_d[cnt_q] = rx_dout[3:0];
                cnt_d      = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                  state_d = ST_READY;
                end else begin
                  state_d = ST_ENTRY;
                end
              end
              ST_READY: begin
                cmd_error_d = 1'b1;
                state_d     = ST_IDLE;
                cnt_d       = 2'd0;
              end
              default: begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
              end
            endcase
          end else begin
            state_d = state_q;
          end
        end
      endcase
    end
`ifdef UART_CMD_TIMEOUT_EN
    else if (tmo_expire_s) begin
      cmd_error_d = 1'b1;
      state_d     = ST_IDLE;
      cnt_d       = 2'd0;
    end
`endif
    else begin
      state_d = state_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State, digit and output registers; reset drops any partial entry at once.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 2'd0;
      d_q[0]       <= 4'd0;
      d_q[1]       <= 4'd0;
      d_q[2]       <= 4'd0;
      d_q[3]       <= 4'd0;
      start_q      <= 1'b0;
      up_q         <= 1'b0;
      dwn_q        <= 1'b0;
      load_valid_q <= 1'b0;
      cmd_error_q  <= 1'b0;
      busy_q       <= 1'b0;
      min_q        <= 6'd0;
      sec_q        <= 6'd0;
`ifdef UART_CMD_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      d_q          <= d_d;
      start_q      <= start_d;
      up_q         <= up_d;
      dwn_q        <= dwn_d;
      load_valid_q <= load_valid_d;
      cmd_error_q  <= cmd_error_d;
      busy_q       <= busy_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
`ifdef UART_CMD_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign start_pulse  = start_q;
  assign up_pulse     = up_q;
  assign dwn_pulse    = dwn_q;
  assign load_valid   = load_valid_q;
  assign cmd_error    = cmd_error_q;
  assign busy         = busy_q;
  assign load_minutes = min_q;
  assign load_seconds = sec_q;

endmodule
